// File: rtl/frame_mac_unit_pkg.sv
// rtl/frame_mac_unit_pkg.sv - shared types, widths and accumulator limits for frame_mac_unit
// Purpose: state enum, default width constants and the signed clamp limits
//          used by the accumulate stage.
// Ports:   none (package).
package frame_mac_pkg;

  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 20;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Largest positive value of a w-bit two's complement accumulator.
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit two's complement accumulator.
  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/frame_mac_unit_if.sv
// rtl/frame_mac_unit_if.sv - operand-pair input and frame-result output bundle
// Purpose: groups the input pair handshake (s_*) and the result handshake (m_*).
// Ports:   s_valid/s_ready/s_a/s_b/s_sub/s_last  operand pair stream
//          m_valid/m_ready/m_data/m_count/m_ovf  per-frame result
//          modport slave  : the MAC engine side
//          modport master : the producer/consumer side
interface frame_mac_if #(
  parameter int DW    = frame_mac_pkg::DW_DEF,
  parameter int ACC_W = frame_mac_pkg::ACC_W_DEF,
  parameter int CNT_W = frame_mac_pkg::CNT_W_DEF
);
  logic             s_valid;
  logic             s_ready;
  logic [DW-1:0]    s_a;
  logic [DW-1:0]    s_b;
  logic             s_sub;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_data;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf;

  modport slave (
    input  s_valid, s_a, s_b, s_sub, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count, m_ovf
  );

  modport master (
    output s_valid, s_a, s_b, s_sub, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count, m_ovf
  );
endinterface

// File: rtl/frame_mac_unit_mac_acc_stage.sv
// rtl/frame_mac_unit_mac_acc_stage.sv - registered signed add/sub accumulator with overflow flag
// Purpose: adds or subtracts the registered product into the frame accumulator
//          and keeps a sticky overflow flag. Build option FRAME_MAC_SATURATE_EN
//          clamps on overflow; otherwise the accumulator wraps.
// Ports:   clk, reset_n      clock, synchronous active-low reset
//          clear             start a new frame (acc and ovf to zero)
//          p_vld/p_sub/p_q   registered product and its add/sub tag
//          acc, ovf          accumulator value and sticky overflow
module mac_acc_stage
  import frame_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             p_vld,
  input  logic             p_sub,
  input  logic [ACC_W-1:0] p_q,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic [ACC_W:0]   ext;
  logic             wrap;
  logic [ACC_W-1:0] acc_nxt;

  // One extra bit of headroom: overflow shows as the top two bits disagreeing.
  // p_q is always non-negative, so it is zero-extended.
  always_comb begin
    ext     = '0;
    wrap    = 1'b0;
    acc_nxt = '0;
    if (p_sub) ext = {acc[ACC_W-1], acc} - {1'b0, p_q};
    else       ext = {acc[ACC_W-1], acc} + {1'b0, p_q};
    wrap = ext[ACC_W] ^ ext[ACC_W-1];
`ifdef FRAME_MAC_SATURATE_EN
    if (wrap) acc_nxt = ext[ACC_W] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
    else      acc_nxt = ext[ACC_W-1:0];
`else
    acc_nxt = ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (p_vld) begin
      acc <= acc_nxt;
      ovf <= ovf | wrap;
    end
  end

endmodule

// File: rtl/frame_mac_unit.sv
// rtl/frame_mac_unit.sv - framed multiply-accumulate engine, one signed sum per frame
// Purpose: accepts unsigned operand pairs, registers each product, accumulates
//          it (add or subtract) and presents the frame sum, pair count and
//          overflow flag on a valid/ready result port. Build option
//          FRAME_MAC_SATURATE_EN selects clamping instead of wrapping.
// Ports:   clk      clock, rising edge
//          reset_n  synchronous active-low reset
//          bus      frame_mac_if.slave (s_* pair stream in, m_* result out)
module frame_mac_unit
  import frame_mac_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  frame_mac_if.slave bus
);

  state_t           state, state_nxt;
  logic             s_ready_c, m_valid_c;
  logic             accept, res_hs;
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] p_q;
  logic             p_vld, p_sub, p_last;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  assign accept = bus.s_valid && s_ready_c;
  assign res_hs = m_valid_c && bus.m_ready;
  assign prod   = (2*DW)'(bus.s_a) * (2*DW)'(bus.s_b);

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = m_valid_c;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ACCUM;
    else          state <= state_nxt;
  end

  // DRAIN covers the final product's register cycle and its accumulate cycle,
  // so the result copy into OUT sees the completed frame sum.
  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    m_valid_c = 1'b0;
    case (state)
      ACCUM: begin
        s_ready_c = 1'b1;
        if (accept && bus.s_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!(p_vld && p_last)) state_nxt = OUT;
      end
      OUT: begin
        m_valid_c = 1'b1;
        if (bus.m_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Product register and frame pair counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_q    <= '0;
      p_vld  <= 1'b0;
      p_sub  <= 1'b0;
      p_last <= 1'b0;
      count  <= '0;
    end else begin
      p_vld <= accept;
      if (accept) begin
        p_q    <= ACC_W'(prod);
        p_sub  <= bus.s_sub;
        p_last <= bus.s_last;
      end
      if (res_hs)                     count <= '0;
      else if (accept && count != '1) count <= count + 1'b1;
    end
  end

  mac_acc_stage #(.ACC_W(ACC_W)) u_acc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (res_hs),
    .p_vld   (p_vld),
    .p_sub   (p_sub),
    .p_q     (p_q),
    .acc     (acc),
    .ovf     (ovf)
  );

  // Result registers load only on entry to OUT and hold through backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.m_data  <= '0;
      bus.m_count <= '0;
      bus.m_ovf   <= 1'b0;
    end else if (state == DRAIN && state_nxt == OUT) begin
      bus.m_data  <= acc;
      bus.m_count <= count;
      bus.m_ovf   <= ovf;
    end
  end

endmodule

// File: tb/tb_frame_mac_unit.sv
// tb/tb_frame_mac_unit.sv - directed self-checking bench for frame_mac_unit
module tb_frame_mac_unit;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  frame_mac_if #(.DW(8), .ACC_W(20), .CNT_W(8)) bus ();

  frame_mac_unit #(.DW(8), .ACC_W(20), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    bus.s_sub   = sub;
    bus.s_last  = last;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_a     = 8'($urandom);
    bus.s_b     = 8'($urandom);
    bus.s_sub   = 1'($urandom);
    bus.s_last  = 1'($urandom);
  endtask

  // Waits for a result, checks it, and lets the handshake complete (m_ready=1).
  task automatic collect(input string tag, input logic [19:0] ed, input logic [7:0] ec, input logic eo);
    int n;
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
    check({tag, "_data"},  32'(bus.m_data),  32'(ed));
    check({tag, "_count"}, 32'(bus.m_count), 32'(ec));
    check({tag, "_ovf"},   32'(bus.m_ovf),   32'(eo));
    @(negedge clk);
  endtask

  initial begin
    logic [19:0] exp_ovf_data;
    int          gap;
    tests = 0;
    fails = 0;
    reset_n     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;
    bus.s_sub   = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_m_count", 32'(bus.m_count), 32'd0);
    check("rst_m_ovf",   32'(bus.m_ovf),   32'd0);

    // 3*4 + 5*6 + 2*10 = 62, with exact two-clock latency and one-cycle valid
    send(8'd3, 8'd4, 1'b0, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    send(8'd2, 8'd10, 1'b0, 1'b1);
    check("lat_e0_valid", 32'(bus.m_valid), 32'd0);
    check("lat_e0_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    check("lat_e1_valid", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check("f1_valid", 32'(bus.m_valid), 32'd1);
    check("f1_data",  32'(bus.m_data),  32'd62);
    check("f1_count", 32'(bus.m_count), 32'd3);
    check("f1_ovf",   32'(bus.m_ovf),   32'd0);
    @(negedge clk);
    check("f1_valid_drop", 32'(bus.m_valid), 32'd0);
    check("f1_ready_back", 32'(bus.s_ready), 32'd1);

    // 100 - 9 = 91, then a fresh frame -1
    send(8'd10, 8'd10, 1'b0, 1'b0);
    send(8'd3, 8'd3, 1'b1, 1'b1);
    collect("f2", 20'd91, 8'd2, 1'b0);
    send(8'd1, 8'd1, 1'b1, 1'b1);
    collect("f3", 20'hFFFFF, 8'd1, 1'b0);

    // Backpressure: result held for 5 cycles
    bus.m_ready = 1'b0;
    send(8'd7, 8'd7, 1'b0, 1'b1);
    gap = 0;
    while (!bus.m_valid && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",   32'(bus.m_valid), 32'd1);
      check("bp_data",    32'(bus.m_data),  32'd49);
      check("bp_count",   32'(bus.m_count), 32'd1);
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.m_valid), 32'd0);
    check("bp_release_ready", 32'(bus.s_ready), 32'd1);

    // Nine 255*255 = 585225 total, beyond +524287
`ifdef FRAME_MAC_SATURATE_EN
    exp_ovf_data = 20'd524287;
`else
    exp_ovf_data = -20'sd463351;
`endif
    for (int i = 0; i < 9; i++) send(8'd255, 8'd255, 1'b0, (i == 8));
    collect("ovf", exp_ovf_data, 8'd9, 1'b1);

    // Reset mid-frame discards the partial sum
    send(8'd5, 8'd5, 1'b0, 1'b0);
    send(8'd6, 8'd6, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mrst_s_ready", 32'(bus.s_ready), 32'd1);
    check("mrst_m_data",  32'(bus.m_data),  32'd0);
    check("mrst_m_count", 32'(bus.m_count), 32'd0);
    check("mrst_m_ovf",   32'(bus.m_ovf),   32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mrst_no_stale", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
    end
    send(8'd2, 8'd2, 1'b0, 1'b1);
    collect("mrst_frame", 20'd4, 8'd1, 1'b0);

    // Gaps with garbage on the data lines: 1*2 + 4*5 = 22
    send(8'd1, 8'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    gap = int'($urandom_range(1, 4));
    repeat (gap) begin
      bus.s_a   = 8'($urandom);
      bus.s_sub = 1'($urandom);
      @(negedge clk);
    end
    send(8'd4, 8'd5, 1'b0, 1'b1);
    collect("gap", 20'd22, 8'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
